// File: rtl/cpu_fetch_pkg.sv
// Shared types and defaults for the fetch sequencer and its decode queue.
package cpu_fetch_pkg;

   localparam int PHYSICAL_ADDR_WIDTH = 32;
   localparam int FETCH_INSTR_WIDTH   = 32;

   localparam logic [PHYSICAL_ADDR_WIDTH-1:0] DEFAULT_RESET_PC   = 'h1000;
   localparam logic [PHYSICAL_ADDR_WIDTH-1:0] DEFAULT_EXC_VECTOR = 'h2000;

   // One fetched slot handed to decode; fault marks an entry standing in for an I-TLB miss.
   typedef struct packed {
      logic [PHYSICAL_ADDR_WIDTH-1:0] pc;
      logic [FETCH_INSTR_WIDTH-1:0]   instr;
      logic                           fault;
   } fetch_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } seq_state_e;

endpackage

// File: rtl/cpu_fetch_sequencer_if.sv
// Fetch-to-decode valid/ready channel. master = sequencer, slave = decode.
interface cpu_fetch_sequencer_if
   import cpu_fetch_pkg::*;
#(
   parameter int PC_WIDTH    = PHYSICAL_ADDR_WIDTH,
   parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
) ();

   logic                   valid;
   logic                   ready;
   logic [INSTR_WIDTH-1:0] instr;
   logic [PC_WIDTH-1:0]    pc;
   logic                   fault;

   modport master (output valid, output instr, output pc, output fault, input ready);
   modport slave  (input valid, input instr, input pc, input fault, output ready);

endinterface

// File: rtl/cpu_fetch_queue.sv
// Two-entry FIFO of fetch entries with flush and same-cycle push/pop at any
// occupancy. Storage is not reset; consumers must qualify head with count.
module cpu_fetch_queue
   import cpu_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop & (count != 2'd0);
   assign do_push = push & ((count != 2'd2) | do_pop);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties the queue outright.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         if (do_push && !do_pop)      count <= count + 2'd1;
         else if (do_pop && !do_push) count <= count - 2'd1;
      end
   end

   // Entry storage write.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/cpu_fetch_sequencer.sv
// Owns the fetch PC: applies redirects, holds on I-cache misses, parks on
// I-TLB faults, and buffers fetched words for decode in a 2-entry queue.
module cpu_fetch_sequencer
   import cpu_fetch_pkg::*;
#(
   parameter int                  PC_WIDTH    = PHYSICAL_ADDR_WIDTH,
   parameter int                  INSTR_WIDTH = FETCH_INSTR_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter logic [PC_WIDTH-1:0] EXC_VECTOR  = DEFAULT_EXC_VECTOR
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   exception_i,
   input  logic                   jump_i,
   input  logic [PC_WIDTH-1:0]    jump_pc_i,
   output logic [PC_WIDTH-1:0]    pc_o,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   input  logic                   cache_hit_i,
   input  logic                   tlb_hit_i,
   input  logic [PC_WIDTH-1:0]    next_pc_i,
   cpu_fetch_sequencer_if.master  dec,
   output logic [15:0]            miss_cnt_o
);

   seq_state_e    state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]   miss_q, miss_d;
   logic          redirect;
   logic          pop;
   logic          full;
   logic          push;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;
   logic [1:0]    count;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign redirect = exception_i | jump_i;
   // A dequeue in a redirect cycle is irrelevant: the flush discards it.
   assign pop      = dec.valid & dec.ready & ~redirect;
   // Full only blocks fetch when the head is not leaving this cycle.
   assign full     = (count == 2'd2) & ~pop;

   // Fetch PC, state and miss counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         miss_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         miss_q  <= miss_d;
      end
   end

   // Next fetch PC, state transition and enqueue decision.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      miss_d     = miss_q;
      push       = 1'b0;
      push_entry = '{pc: pc_q, instr: instr_i, fault: 1'b0};
      if (exception_i) begin
         pc_d    = EXC_VECTOR;
         state_d = RUN;
      end else if (jump_i) begin
         pc_d    = jump_pc_i;
         state_d = RUN;
      end else if (state_q == RUN && !full) begin
         if (!tlb_hit_i) begin
            push             = 1'b1;
            push_entry.instr = '0;
            push_entry.fault = 1'b1;
            state_d          = FAULT;
         end else if (cache_hit_i) begin
            push = 1'b1;
            pc_d = next_pc_i;
         end else begin
            miss_d = sat_inc16(miss_q);
         end
      end
   end

   cpu_fetch_queue u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .count      (count),
      .head       (head)
   );

   assign pc_o       = pc_q;
   assign miss_cnt_o = miss_q;
   assign dec.valid  = (count != 2'd0);
   assign dec.instr  = dec.valid ? head.instr : '0;
   assign dec.pc     = dec.valid ? head.pc    : '0;
   assign dec.fault  = dec.valid & head.fault;

endmodule
